// File: rtl/fir_bram_arbiter_if.sv
// fir_bram_arbiter_if
// Purpose : requester-side bundle of one port into the FIR BRAM arbiter. It is
//           instantiated once for the cfg (AXI-Lite tap) path and once for the
//           engine path.
// Ports   : req/we/addr/wdata  requester -> arbiter
//           gnt/rvalid/rdata   arbiter -> requester
// Modports: master = requester side, slave = arbiter side.
interface fir_bram_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 32
) ();
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/fir_bram_arbiter.sv
// fir_bram_arbiter
// Purpose : shares one single-port FIR BRAM between the cfg (host tap access)
//           path and the FIR compute engine. Grants are combinational, cfg
//           writes are dropped (with cfg_err) while the engine is busy, and
//           read data is steered back to whichever side issued the read.
// Ports   : axis_clk, axis_rst_n (async, active-low)
//           cfg  : requester bundle for the configuration path (slave modport)
//           eng  : requester bundle for the compute engine (slave modport)
//           cfg_err  one-cycle pulse when a cfg write is dropped
//           eng_busy engine computing; cfg write-protect window
//           bram_EN/WE/A/Di/Do  single BRAM port, Do valid one cycle after A
// Build   : FIR_BRAM_ARB_RR_EN defined   -> pure round-robin arbitration
//           FIR_BRAM_ARB_RR_EN undefined -> engine priority with starvation
//                                           forcing after STARVE_LIMIT cycles
//
// state   | meaning
// --------+-----------------------------------------------
// ARB_ENG | engine wins when both request
// ARB_CFG | cfg wins when both request
module fir_bram_arbiter #(
    parameter int pADDR_WIDTH  = 12,
    parameter int pDATA_WIDTH  = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    fir_bram_arbiter_if.slave      cfg,
    fir_bram_arbiter_if.slave      eng,
    output logic                   cfg_err,
    input  logic                   eng_busy,
    output logic                   bram_EN,
    output logic [3:0]             bram_WE,
    output logic [pADDR_WIDTH-1:0] bram_A,
    output logic [pDATA_WIDTH-1:0] bram_Di,
    input  logic [pDATA_WIDTH-1:0] bram_Do
);

    typedef enum logic {ARB_ENG = 1'b0, ARB_CFG = 1'b1} arb_state_e;

    arb_state_e state_q, state_d;
    logic       rd_vld_q, rd_vld_d;
    logic       rd_own_q, rd_own_d;    // 1 = pending read belongs to cfg
    logic       cfg_win, eng_win;
    logic       cfg_wr, wr_en;
`ifndef FIR_BRAM_ARB_RR_EN
    logic [3:0] starve_cnt_q, starve_cnt_d;
`endif

    always_comb begin
        cfg_win  = cfg.req & (~eng.req | (state_q == ARB_CFG));
        eng_win  = eng.req & ~cfg_win;

        // A blocked cfg write still retires (gnt) but never reaches the BRAM.
        cfg_wr   = cfg_win & cfg.we;
        cfg_err  = cfg_wr & eng_busy;
        wr_en    = (cfg_wr & ~eng_busy) | (eng_win & eng.we);

        bram_EN  = cfg_win | eng_win;
        bram_WE  = {4{wr_en}};
        bram_A   = '0;
        bram_Di  = '0;
        if (cfg_win) begin
            bram_A  = cfg.addr;
            bram_Di = cfg.wdata;
        end else if (eng_win) begin
            bram_A  = eng.addr;
            bram_Di = eng.wdata;
        end

        rd_vld_d = (cfg_win & ~cfg.we) | (eng_win & ~eng.we);
        rd_own_d = cfg_win;

        state_d  = state_q;
`ifdef FIR_BRAM_ARB_RR_EN
        if (cfg_win) begin
            state_d = ARB_ENG;
        end else if (eng_win) begin
            state_d = ARB_CFG;
        end
`else
        starve_cnt_d = '0;
        if (cfg.req & ~cfg_win) begin
            // Saturate so an out-of-range limit can never wrap back to zero.
            starve_cnt_d = (starve_cnt_q == 4'hF) ? starve_cnt_q : starve_cnt_q + 4'd1;
        end
        case (state_q)
            ARB_ENG: if (starve_cnt_d >= 4'(STARVE_LIMIT)) state_d = ARB_CFG;
            ARB_CFG: if (cfg_win | ~cfg.req)               state_d = ARB_ENG;
            default: state_d = ARB_ENG;
        endcase
`endif
    end

    assign cfg.gnt    = cfg_win;
    assign eng.gnt    = eng_win;
    assign cfg.rvalid = rd_vld_q & rd_own_q;
    assign eng.rvalid = rd_vld_q & ~rd_own_q;
    assign cfg.rdata  = cfg.rvalid ? bram_Do : '0;
    assign eng.rdata  = eng.rvalid ? bram_Do : '0;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q  <= ARB_ENG;
            rd_vld_q <= 1'b0;
            rd_own_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_vld_q <= rd_vld_d;
            rd_own_q <= rd_own_d;
        end
    end

`ifndef FIR_BRAM_ARB_RR_EN
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_fir_bram_arbiter.sv
module tb_fir_bram_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SL = 4;

    logic          axis_clk = 1'b0;
    logic          axis_rst_n;
    logic          eng_busy;
    logic          cfg_err;
    logic          bram_EN;
    logic [3:0]    bram_WE;
    logic [AW-1:0] bram_A;
    logic [DW-1:0] bram_Di;
    logic [DW-1:0] bram_Do;

    logic          c_req, c_we, e_req, e_we;
    logic [AW-1:0] c_addr, e_addr;
    logic [DW-1:0] c_wdata, e_wdata;

    always #5 axis_clk = ~axis_clk;

    fir_bram_arbiter_if #(.AW(AW), .DW(DW)) cfg_if ();
    fir_bram_arbiter_if #(.AW(AW), .DW(DW)) eng_if ();

    assign cfg_if.req   = c_req;
    assign cfg_if.we    = c_we;
    assign cfg_if.addr  = c_addr;
    assign cfg_if.wdata = c_wdata;
    assign eng_if.req   = e_req;
    assign eng_if.we    = e_we;
    assign eng_if.addr  = e_addr;
    assign eng_if.wdata = e_wdata;

    fir_bram_arbiter #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .cfg        (cfg_if),
        .eng        (eng_if),
        .cfg_err    (cfg_err),
        .eng_busy   (eng_busy),
        .bram_EN    (bram_EN),
        .bram_WE    (bram_WE),
        .bram_A     (bram_A),
        .bram_Di    (bram_Di),
        .bram_Do    (bram_Do)
    );

    // Single-port BRAM: byte writes, registered read.
    logic [DW-1:0] bram_mem [0:1023];
    always @(posedge axis_clk) begin
        if (bram_EN) begin
            for (int b = 0; b < 4; b++)
                if (bram_WE[b]) bram_mem[bram_A[AW-1:2]][8*b +: 8] <= bram_Di[8*b +: 8];
            if (bram_WE == 4'h0) bram_Do <= bram_mem[bram_A[AW-1:2]];
        end
    end

    // Reference model state.
    int            errors = 0;
    int            checks = 0;
    int            waited;
    bit            pref_cfg;
    bit            pv_cfg, pv_eng;
    logic [DW-1:0] pv_data;
    logic [DW-1:0] ref_mem [0:15];
    logic [DW-1:0] pf [0:15];

    logic          obs_cg, obs_eg, obs_err, obs_en, obs_crv, obs_erv;
    logic [3:0]    obs_we;
    logic [AW-1:0] obs_a;
    logic [DW-1:0] obs_di, obs_crd, obs_erd;
    bit            last_cg, last_eg;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        waited   = 0;
        pref_cfg = 1'b0;
        pv_cfg   = 1'b0;
        pv_eng   = 1'b0;
        pv_data  = '0;
    endtask

    task automatic idle_inputs();
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0;
        eng_busy = 0;
    endtask

    // One clock: check outputs at negedge against the model, then advance the model.
    task automatic tick();
        logic          cg, eg, wr;
        logic [AW-1:0] a;
        logic [DW-1:0] di;
        @(negedge axis_clk);
`ifdef FIR_BRAM_ARB_RR_EN
        cg = c_req && (!e_req || pref_cfg);
`else
        cg = c_req && (!e_req || waited >= SL);
`endif
        eg = e_req && !cg;
        wr = (cg && c_we && !eng_busy) || (eg && e_we);
        a  = cg ? c_addr  : (eg ? e_addr  : '0);
        di = cg ? c_wdata : (eg ? e_wdata : '0);
        obs_cg  = cfg_if.gnt;    obs_eg  = eng_if.gnt;   obs_err = cfg_err;
        obs_en  = bram_EN;       obs_we  = bram_WE;      obs_a   = bram_A;
        obs_di  = bram_Di;       obs_crv = cfg_if.rvalid; obs_erv = eng_if.rvalid;
        obs_crd = cfg_if.rdata;  obs_erd = eng_if.rdata;
        chk("cfg_gnt",    32'(obs_cg),  32'(cg));
        chk("eng_gnt",    32'(obs_eg),  32'(eg));
        chk("cfg_err",    32'(obs_err), 32'(cg && c_we && eng_busy));
        chk("bram_EN",    32'(obs_en),  32'(cg || eg));
        chk("bram_WE",    32'(obs_we),  wr ? 32'hF : 32'h0);
        chk("bram_A",     32'(obs_a),   32'(a));
        chk("bram_Di",    obs_di,       di);
        chk("cfg_rvalid", 32'(obs_crv), 32'(pv_cfg));
        chk("eng_rvalid", 32'(obs_erv), 32'(pv_eng));
        chk("cfg_rdata",  obs_crd,      pv_cfg ? pv_data : '0);
        chk("eng_rdata",  obs_erd,      pv_eng ? pv_data : '0);
        @(posedge axis_clk);
        if (!axis_rst_n) begin
            model_reset();
        end else begin
            pv_cfg = cg && !c_we;
            pv_eng = eg && !e_we;
            if (pv_cfg) pv_data = ref_mem[c_addr[5:2]];
            else if (pv_eng) pv_data = ref_mem[e_addr[5:2]];
            if (cg && c_we && !eng_busy) ref_mem[c_addr[5:2]] = c_wdata;
            if (eg && e_we) ref_mem[e_addr[5:2]] = e_wdata;
            if (c_req && !cg) waited++; else waited = 0;
            if (cg) pref_cfg = 1'b0; else if (eg) pref_cfg = 1'b1;
        end
        last_cg = cg;
        last_eg = eg;
        #1;
    endtask

    task automatic starve_run(input string tag);
        bit exp_c;
        c_req = 1; c_we = 0; c_addr = 12'h008;
        e_req = 1; e_we = 0; e_addr = 12'h000;
        for (int k = 1; k <= 6; k++) begin
            tick();
`ifdef FIR_BRAM_ARB_RR_EN
            exp_c = (k % 2 == 0);
`else
            exp_c = (k == SL + 1);
`endif
            chk({tag, "_cfg"}, 32'(obs_cg), 32'(exp_c));
            chk({tag, "_eng"}, 32'(obs_eg), 32'(!exp_c));
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        axis_rst_n = 0;
        repeat (3) tick();
        axis_rst_n = 1;
        tick();
        chk("rst_gnt",    32'({obs_cg, obs_eg}),   32'h0);
        chk("rst_rvalid", 32'({obs_crv, obs_erv}), 32'h0);
        chk("rst_bram",   32'({obs_en, obs_we}),   32'h0);
        chk("rst_err",    32'(obs_err),            32'h0);

        // Fill the low 16 words through the cfg path; word 1 carries 5.
        for (int w = 0; w < 16; w++) begin
            pf[w] = (w == 1) ? 32'h5 : $urandom;
            c_req = 1; c_we = 1; c_addr = AW'(w * 4); c_wdata = pf[w];
            tick();
            if (w == 1) begin
                chk("wr_gnt", 32'(obs_cg), 32'h1);
                chk("wr_we",  32'(obs_we), 32'hF);
                chk("wr_a",   32'(obs_a),  32'h004);
                chk("wr_di",  obs_di,      32'h5);
            end
        end
        idle_inputs();
        tick();

        c_req = 1; c_we = 0; c_addr = 12'h004;
        tick();
        chk("rd_gnt", 32'(obs_cg), 32'h1);
        idle_inputs();
        tick();
        chk("rd_cfg_rvalid", 32'(obs_crv), 32'h1);
        chk("rd_cfg_rdata",  obs_crd,      32'h5);
        chk("rd_eng_rvalid", 32'(obs_erv), 32'h0);

        starve_run("starve");

        eng_busy = 1; c_req = 1; c_we = 1; c_addr = 12'h008; c_wdata = 32'hDEAD_BEEF;
        tick();
        chk("wp_gnt", 32'(obs_cg),  32'h1);
        chk("wp_err", 32'(obs_err), 32'h1);
        chk("wp_we",  32'(obs_we),  32'h0);
        eng_busy = 0; c_we = 0;
        tick();
        idle_inputs();
        tick();
        chk("wp_readback", obs_crd, pf[2]);

        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            if (i % 2 == 0) begin e_req = 1; e_addr = 12'h000; end
            else            begin c_req = 1; c_addr = 12'h004; end
            tick();
            if (i > 0) begin
                chk("alt_eng_rv", 32'(obs_erv), 32'(i % 2 == 1));
                chk("alt_cfg_rv", 32'(obs_crv), 32'(i % 2 == 0));
                chk("alt_data",   obs_crd | obs_erd, (i % 2 == 1) ? pf[0] : 32'h5);
            end
        end
        idle_inputs();
        tick();

        // Build up starvation, leave an engine read in flight, then reset.
        c_req = 1; c_we = 0; c_addr = 12'h00C;
        e_req = 1; e_we = 0; e_addr = 12'h010;
        repeat (3) tick();
        idle_inputs();
        axis_rst_n = 0;
        model_reset();
        tick();
        chk("mid_rst_rvalid", 32'({obs_crv, obs_erv}), 32'h0);
        tick();
        axis_rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_rvalid", 32'({obs_crv, obs_erv}), 32'h0);
        end
        starve_run("post_rst");

        for (int n = 0; n < 1500; n++) begin
            if (!c_req || last_cg || $urandom_range(15) == 0) begin
                c_req = ($urandom_range(2) != 0);
                c_we = 1'($urandom_range(1)); c_addr = AW'($urandom_range(15) * 4);
                c_wdata = $urandom;
            end
            if (!e_req || last_eg || $urandom_range(15) == 0) begin
                e_req = ($urandom_range(3) != 0);
                e_we = 1'($urandom_range(1)); e_addr = AW'($urandom_range(15) * 4);
                e_wdata = $urandom;
            end
            eng_busy = ($urandom_range(2) == 0);
            tick();
        end
        idle_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fir_bram_arbiter.md
# fir_bram_arbiter

Two-requester arbiter for a single-port FIR coefficient/data BRAM. It lets the AXI-Lite configuration path (host tap reads/writes) and the FIR compute engine share one BRAM port. Requests are serialised, read-return data is steered to the requester whose read was granted, and tap writes are blocked while the engine is busy. It sits between the FIR control/compute logic and the `tap_*` or `data_*` BRAM port of the FIR top level.

## Interface
- pADDR_WIDTH, 12, BRAM byte-address width
- pDATA_WIDTH, 32, BRAM data width
- STARVE_LIMIT, 4, consecutive denied cfg cycles before cfg is forced to win (1..15)

- axis_clk  in  1  clock
- axis_rst_n  in  1  asynchronous, active-low reset
- cfg_req  in  1  cfg access request; held until cfg_gnt
- cfg_we  in  1  1 = write, 0 = read
- cfg_addr  in  pADDR_WIDTH  cfg byte address
- cfg_wdata  in  pDATA_WIDTH  cfg write data
- cfg_gnt  out  1  cfg access performed this cycle
- cfg_rvalid  out  1  cfg read data valid
- cfg_rdata  out  pDATA_WIDTH  cfg read data
- cfg_err  out  1  one-cycle pulse: cfg write dropped because the engine was busy
- eng_busy  in  1  engine computing; the cfg write-protect window
- eng_req  in  1  engine access request
- eng_we  in  1  engine write enable
- eng_addr  in  pADDR_WIDTH  engine byte address
- eng_wdata  in  pDATA_WIDTH  engine write data
- eng_gnt  out  1  engine access performed this cycle
- eng_rvalid  out  1  engine read data valid
- eng_rdata  out  pDATA_WIDTH  engine read data
- bram_EN  out  1  BRAM enable
- bram_WE  out  4  BRAM byte write enables
- bram_A  out  pADDR_WIDTH  BRAM address
- bram_Di  out  pDATA_WIDTH  BRAM write data
- bram_Do  in  pDATA_WIDTH  BRAM read data; valid one cycle after address

## Operation
- **Grant is combinational from state and requests.** At most one of cfg_gnt/eng_gnt is high per cycle. The granted requester's address and data drive the BRAM in the same cycle.
- **BRAM drive**
  - bram_EN = cfg_gnt | eng_gnt.
  - bram_WE = 4'b1111 on a granted write, else 0.
  - bram_A and bram_Di are 0 when nothing is granted.
- **FSM states:** ARB_ENG (engine preferred) and ARB_CFG (cfg preferred).
  - In ARB_ENG: engine wins when both request.
  - In ARB_CFG: cfg wins when both request.
  - A lone requester is always granted.
- **Starvation counter** (4 bits)
  - Increments each cycle cfg_req=1 and cfg_gnt=0.
  - Clears on cfg_gnt, or on cfg_req=0.
  - ARB_ENG -> ARB_CFG when the counter reaches STARVE_LIMIT.
  - ARB_CFG -> ARB_ENG after a cfg grant, or when cfg_req drops.
- **Write protect**
  - A cfg write granted while eng_busy=1 still asserts cfg_gnt (the request retires). bram_WE stays 0 and cfg_err pulses that cycle.
  - cfg reads are never blocked.
- **Read return**
  - A registered tag {valid, owner} is set on each granted read.
  - Next cycle: the owner's rvalid = 1 and its rdata = bram_Do. The other requester's rdata = 0.
  - Back-to-back reads, including alternating owners, are supported at one per cycle.
- **Writes** produce no rvalid.

## Timing
- Reset values:
  - Read tag = invalid; FSM = ARB_ENG; starvation counter = 0.
  - All outputs 0: gnt, rvalid, rdata, cfg_err, bram_*.
- Grant latency is 0 cycles when uncontended. Read latency is exactly 1 cycle from grant to rvalid.
- Worst-case cfg wait under continuous eng_req is STARVE_LIMIT cycles. Grant occurs in cycle STARVE_LIMIT+1.
- A request dropped before its grant is discarded with no side effects.
- Reset asserted mid-read: the pending rvalid is suppressed and no rvalid appears after reset release.
- eng_busy is sampled in the grant cycle only.

## Configuration
- **Macro `FIR_BRAM_ARB_RR_EN`**
  - Defined: pure round-robin. A grant to X moves the FSM to prefer the other requester. The starvation counter and STARVE_LIMIT are unused.
  - Undefined: engine-priority scheme with starvation forcing, as described above.
- Write protect and read return are identical in both builds.

## Test plan
- Reset, then idle -> all outputs 0. Single cfg write to 0x004 with data 0x0000_0005, eng_busy=0 -> cfg_gnt for 1 cycle, bram_WE=4'hF, bram_A=0x004, bram_Di=5.
- cfg read of 0x004 -> cfg_gnt in cycle N; cfg_rvalid=1 and cfg_rdata=5 in cycle N+1; eng_rvalid=0.
- eng_req held high continuously with cfg_req high, STARVE_LIMIT=4 -> eng_gnt for 4 cycles, cfg_gnt in cycle 5, eng_gnt resumes in cycle 6. Under `FIR_BRAM_ARB_RR_EN`: grants alternate every cycle.
- eng_busy=1 with cfg write to 0x008 -> cfg_gnt=1, cfg_err=1, bram_WE=0; a subsequent read of 0x008 returns the old value.
- Alternating eng read 0x000 and cfg read 0x004, one per cycle -> rvalid alternates between eng and cfg, each carrying the matching BRAM word; no cross-delivery.
- Reset asserted in the cycle after a granted read -> no rvalid seen after reset; FSM in ARB_ENG, starvation counter 0.
